// File: rtl/clk_ctrl.sv
// Run/halt/single-step controller for the CPU clock divider.
// Divisor updates are held pending and applied only at period boundaries (or at once while halted).
module clk_ctrl #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cpu_clk,
  output logic             cpu_ce,
  output logic [WIDTH-1:0] div_cur,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_div, w_div_next;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pending, w_pending_next;
  logic             r_cpu_clk, w_cpu_clk_next;
  logic             r_cpu_ce, w_cpu_ce_next;
  logic             w_accept;
  logic             w_phase_end;

  assign w_accept    = cfg_valid & ~r_pending;
  assign w_phase_end = (r_cnt == r_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_HALT;
      r_cnt      <= '0;
      r_div      <= DEFAULT_DIV;
      r_pend_div <= '0;
      r_pending  <= 1'b0;
      r_cpu_clk  <= 1'b1;
      r_cpu_ce   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_div     <= w_div_next;
      r_pending <= w_pending_next;
      r_cpu_clk <= w_cpu_clk_next;
      r_cpu_ce  <= w_cpu_ce_next;
      if (w_accept) begin
        r_pend_div <= cfg_div;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_div_next     = r_div;
    w_pending_next = r_pending;
    w_cpu_clk_next = r_cpu_clk;
    w_cpu_ce_next  = 1'b0;

    // Accept and apply are mutually exclusive: accept needs no pending update, apply needs one.
    if (w_accept) begin
      w_pending_next = 1'b1;
    end

    case (r_state)
      S_HALT: begin
        w_cnt_next     = '0;
        w_cpu_clk_next = 1'b1;
        if (r_pending) begin
          w_div_next     = r_pend_div;
          w_pending_next = 1'b0;
        end else if (!w_accept) begin
          // An update arriving this cycle also holds off the start, so the new divisor governs it.
          if (run) begin
            w_state_next   = S_RUN;
            w_cpu_clk_next = 1'b0;
          end else if (step) begin
            w_state_next   = S_STEP;
            w_cpu_clk_next = 1'b0;
          end
        end
      end

      default: begin
        if (r_state == S_RUN && !run) begin
          w_state_next = S_DRAIN;
        end else if (r_state == S_DRAIN && run) begin
          w_state_next = S_RUN;
        end

        if (!w_phase_end) begin
          w_cnt_next = r_cnt + WIDTH'(1);
        end else begin
          w_cnt_next = '0;
          if (!r_cpu_clk) begin
            w_cpu_clk_next = 1'b1;
            w_cpu_ce_next  = 1'b1;
          end else begin
            if (r_pending) begin
              w_div_next     = r_pend_div;
              w_pending_next = 1'b0;
            end
            if (r_state == S_STEP || (r_state == S_DRAIN && !run)) begin
              w_state_next = S_HALT;
            end else begin
              w_cpu_clk_next = 1'b0;
            end
          end
        end
      end
    endcase
  end

  assign cfg_ready = ~r_pending;
  assign cpu_clk   = r_cpu_clk;
  assign cpu_ce    = r_cpu_ce;
  assign div_cur   = r_div;
  assign state     = r_state;

endmodule
